// File: rtl/input_binarize_packer.sv
// input_binarize_packer: thresholds pixel beats to bits, packs them into words, frames images.
// Rev 1.0. Optional BINARIZE_THRESHOLD_CFG_EN adds a per-image cfg_threshold port.
`default_nettype none

module input_binarize_packer #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int PIXELS_PER_BEAT  = 4,
  parameter int OUTPUT_WIDTH     = 64,
  parameter int IMAGE_PIXELS     = 784
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [PIXELS_PER_BEAT*INPUT_DATA_WIDTH-1:0] in_data,
  input  logic                                        in_last,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [OUTPUT_WIDTH-1:0]                     out_data,
  output logic                                        out_last,
  output logic                                        busy,
  output logic                                        frame_err,
`ifdef BINARIZE_THRESHOLD_CFG_EN
  input  logic [INPUT_DATA_WIDTH-1:0]                 cfg_threshold,
`endif
  output logic [15:0]                                 image_count
);

  localparam int PCW = $clog2(IMAGE_PIXELS + 1);
  localparam int BCW = $clog2(OUTPUT_WIDTH + 1);
  localparam logic [PCW-1:0] PIX_STEP  = PCW'(PIXELS_PER_BEAT);
  localparam logic [PCW-1:0] PIX_TOTAL = PCW'(IMAGE_PIXELS);
  localparam logic [BCW-1:0] BIT_STEP  = BCW'(PIXELS_PER_BEAT);
  localparam logic [BCW-1:0] BIT_TOTAL = BCW'(OUTPUT_WIDTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                      state;
  logic [PCW-1:0]              pixel_cnt;
  logic [BCW-1:0]              bit_cnt;
  logic [OUTPUT_WIDTH-1:0]     acc;
  logic [INPUT_DATA_WIDTH-1:0] thr;
  logic [PIXELS_PER_BEAT-1:0]  beat_bits;
  logic [OUTPUT_WIDTH-1:0]     merged;
  logic [PCW-1:0]              pix_next;
  logic [BCW-1:0]              bits_next;
  logic                        accept;
  logic                        img_end;
  logic                        word_end;
  logic                        pop;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

`ifdef BINARIZE_THRESHOLD_CFG_EN
  logic [INPUT_DATA_WIDTH-1:0] thr_hold;

  // The first beat of an image already uses the live value being captured.
  assign thr = (state == IDLE) ? cfg_threshold : thr_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_hold <= '0;
    end else if (accept && state == IDLE) begin
      thr_hold <= cfg_threshold;
    end
  end
`else
  assign thr = {1'b1, {(INPUT_DATA_WIDTH-1){1'b0}}};
`endif

  generate
    for (genvar k = 0; k < PIXELS_PER_BEAT; k++) begin : g_lane
      assign beat_bits[k] = (in_data[k*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH] >= thr);
    end
  endgenerate

  assign merged    = acc | (OUTPUT_WIDTH'(beat_bits) << bit_cnt);
  assign pix_next  = pixel_cnt + PIX_STEP;
  assign bits_next = bit_cnt + BIT_STEP;
  assign img_end   = (pix_next == PIX_TOTAL);
  assign word_end  = (bits_next == BIT_TOTAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      pixel_cnt   <= '0;
      bit_cnt     <= '0;
      acc         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      frame_err   <= 1'b0;
      image_count <= '0;
    end else begin
      if (accept) begin
        if (img_end) begin
          state     <= IDLE;
          busy      <= 1'b0;
          pixel_cnt <= '0;
        end else begin
          state     <= RUN;
          busy      <= 1'b1;
          pixel_cnt <= pix_next;
        end

        // in_last is only audited; the pixel counter alone decides framing.
        if (in_last != img_end) begin
          frame_err <= 1'b1;
        end

        if (img_end || word_end) begin
          acc      <= '0;
          bit_cnt  <= '0;
          out_data <= merged;
          out_last <= img_end;
        end else begin
          acc     <= merged;
          bit_cnt <= bits_next;
        end
      end

      if (accept && (img_end || word_end)) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (pop && out_last) begin
        image_count <= image_count + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/input_binarize_packer.md
# input_binarize_packer

Streaming front end of the BNN fully-connected pipeline. Accepts raw pixel beats over a valid/ready interface, binarizes each pixel against a threshold (pixel >= threshold -> 1), and packs the resulting bits into OUTPUT_WIDTH-bit words for the first binary layer. It sequences image framing with counters, zero-pads and tags the final word of each image, and counts completed images.

## Interface
- INPUT_DATA_WIDTH, 8, bits per pixel
- PIXELS_PER_BEAT, 4, pixels per input beat; OUTPUT_WIDTH must be a multiple of it
- OUTPUT_WIDTH, 64, bits per packed output word
- IMAGE_PIXELS, 784, pixels per image; must be a multiple of PIXELS_PER_BEAT
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  PIXELS_PER_BEAT*INPUT_DATA_WIDTH  lane k = bits [k*W +: W], lane 0 = earliest pixel
- in_last  in  1  producer's end-of-image marker; checked only, never used for framing
- out_valid  out  1  packed word valid
- out_ready  in  1  downstream accepts word
- out_data  out  OUTPUT_WIDTH  packed bits
- out_last  out  1  word is the final word of an image
- busy  out  1  image in progress (state RUN)
- frame_err  out  1  sticky: in_last disagreed with internal pixel count
- image_count  out  16  completed images, wraps 0xFFFF -> 0
- cfg_threshold  in  INPUT_DATA_WIDTH  present only with BINARIZE_THRESHOLD_CFG_EN

## Operation
- States: IDLE (no beat of current image accepted yet), RUN (pixel_cnt > 0).
- IDLE -> RUN on first accepted beat; RUN -> IDLE on acceptance of beat that makes pixel_cnt reach IMAGE_PIXELS.
- Pixel i of an image maps to bit (i mod OUTPUT_WIDTH) of word floor(i / OUTPUT_WIDTH).
- bit_cnt tracks fill of accumulator; when an accepted beat fills bit_cnt to OUTPUT_WIDTH, or ends the image, the completed word (accumulator plus this beat's bits) loads the output register in that same edge; accumulator and bit_cnt clear.
- Final partial word: unused high bits are 0; out_last = 1. Other words out_last = 0.
- If IMAGE_PIXELS is a multiple of OUTPUT_WIDTH, the last full word carries out_last.
- in_ready = !out_valid || out_ready (combinational; single output register, no skid).
- out_valid clears on out_ready when no new word loads the same cycle; simultaneous pop and load keeps out_valid = 1 with new data.
- frame_err sets if in_last = 1 on a non-final accepted beat, or in_last = 0 on the final beat. Framing still follows the counter.
- image_count increments on the edge the out_last word is accepted downstream (out_valid && out_ready && out_last).
- Threshold comparison is unsigned, full INPUT_DATA_WIDTH.

## Timing
- Reset values: out_valid 0, out_data 0, out_last 0, busy 0, frame_err 0, image_count 0, state IDLE, all counters 0; in_ready reads 1 during and after reset.
- Latency: word visible on out_valid the cycle after the completing beat is accepted.
- Throughput: one beat per cycle with out_ready held high; OUTPUT_WIDTH/PIXELS_PER_BEAT beats per word.
- Back-to-back images: first beat of image N+1 may be accepted the cycle after the last beat of image N.
- out_data/out_last hold stable while out_valid && !out_ready.
- rst_n low mid-image: partial word, counters and pending output discarded immediately.

## Configuration
- BINARIZE_THRESHOLD_CFG_EN defined: cfg_threshold port exists; value is sampled on the IDLE -> RUN transition and held for the whole image; mid-image changes have no effect.
- Undefined: no cfg_threshold port; threshold fixed at 2^(INPUT_DATA_WIDTH-1) (128 for 8-bit).

## Test plan
- All pixels 0xFF, defaults, out_ready = 1 -> 13 words: 12 of 0xFFFF_FFFF_FFFF_FFFF, 13th 0x0000_0000_0000_FFFF with out_last = 1; image_count = 1.
- Pixel values 127/128 alternating (lane 0 = 127) -> every word 0xAAAA_AAAA_AAAA_AAAA; final word 0x0000_0000_0000_AAAA.
- out_ready toggled randomly 50% -> in_ready low exactly when out_valid && !out_ready; no words lost or duplicated; data stable while stalled.
- in_last asserted on beat 100 of 196 -> frame_err = 1 and stays 1; framing still ends at beat 196.
- Reset asserted after 50 beats, then full image -> first word after reset contains only new-image pixels; image_count = 1.
- With BINARIZE_THRESHOLD_CFG_EN, cfg_threshold = 0x10 at image start, changed to 0xF0 mid-image, pixels 0x20 -> all valid bits 1.
